// File: rtl/hud_score_if.sv
// rtl/hud_score_if.sv - game event inputs and frame-synchronous HUD outputs of the score controller
interface hud_score_if;
  logic        frame_start;
  logic        new_game;
  logic        alien_kill;
  logic [1:0]  alien_type;
  logic        player_hit;
  logic [13:0] score_out;
  logic [15:0] score_bcd;
  logic [1:0]  lives_out;
  logic        hud_blank_lives;
  logic        game_over;
  logic        busy;

  modport master (
    output frame_start, new_game, alien_kill, alien_type, player_hit,
    input  score_out, score_bcd, lives_out, hud_blank_lives, game_over, busy
  );

  modport slave (
    input  frame_start, new_game, alien_kill, alien_type, player_hit,
    output score_out, score_bcd, lives_out, hud_blank_lives, game_over, busy
  );
endinterface

// File: rtl/hud_score_ctrl.sv
// rtl/hud_score_ctrl.sv - score, lives, blink and game-over control with tear-free HUD publishing
module hud_score_ctrl #(
  parameter int START_LIVES   = 3,
  parameter int BLINK_FRAMES  = 60,
  parameter int EXTRA_LIFE_AT = 1500
) (
  input  logic        clk,
  input  logic        rst,
  hud_score_if.slave  hud
);
  localparam logic [1:0]  START_L  = 2'(START_LIVES);
  localparam logic [7:0]  BLINK_N  = 8'(BLINK_FRAMES);
  localparam logic [13:0] EXTRA_AT = 14'(EXTRA_LIFE_AT);
  localparam logic [13:0] SCORE_MAX = 14'd9990;

  typedef enum logic [1:0] {ATTRACT, PLAY, HIT, OVER} state_t;

  state_t      state;
  logic [13:0] score_bin;
  logic [15:0] bcd;
  logic [7:0]  pending;
  logic [1:0]  lives;
  logic [7:0]  blink_cnt;
  logic        extra_done;

  logic [13:0] score_out_r;
  logic [15:0] score_bcd_r;
  logic [1:0]  lives_out_r;
  logic        blank_r;

  logic [3:0]  kill_tens;
  logic        credit, drain, add, award, hit;
  logic [8:0]  pend_sum;
  logic [7:0]  pend_next;
  logic [13:0] score_next;
  logic [15:0] bcd_next;
  logic [1:0]  lives_inc, lives_hit;

  always_comb begin
    kill_tens = 4'd1;
    case (hud.alien_type)
      2'd0:    kill_tens = 4'd1;
      2'd1:    kill_tens = 4'd2;
      2'd2:    kill_tens = 4'd3;
      default: kill_tens = 4'd10;
    endcase
  end

  assign credit    = hud.alien_kill && (state == PLAY || state == HIT);
  assign drain     = (pending != 8'd0);
  assign add       = drain && (score_bin < SCORE_MAX);
  assign pend_sum  = {1'b0, pending} + (credit ? {5'd0, kill_tens} : 9'd0) - {8'd0, drain};
  assign pend_next = (pend_sum > 9'd255) ? 8'hFF : pend_sum[7:0];
  assign score_next = add ? score_bin + 14'd10 : score_bin;

  // Only the tens digit ever steps; the ones digit stays 0 and saturation keeps thousands <= 9.
  always_comb begin
    bcd_next = bcd;
    if (add) begin
      if (bcd[7:4] != 4'd9) begin
        bcd_next[7:4] = bcd[7:4] + 4'd1;
      end else begin
        bcd_next[7:4] = 4'd0;
        if (bcd[11:8] != 4'd9) begin
          bcd_next[11:8] = bcd[11:8] + 4'd1;
        end else begin
          bcd_next[11:8]  = 4'd0;
          bcd_next[15:12] = bcd[15:12] + 4'd1;
        end
      end
    end
  end

  assign award     = !extra_done && (score_bin >= EXTRA_AT) && (state != OVER);
  assign lives_inc = (award && lives != 2'd3) ? lives + 2'd1 : lives;
  assign hit       = hud.player_hit && (state == PLAY);
  assign lives_hit = lives_inc - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ATTRACT;
      score_bin   <= '0;
      bcd         <= '0;
      pending     <= '0;
      lives       <= '0;
      blink_cnt   <= '0;
      extra_done  <= 1'b0;
      score_out_r <= '0;
      score_bcd_r <= '0;
      lives_out_r <= '0;
      blank_r     <= 1'b0;
    end else if (hud.new_game) begin
      state      <= PLAY;
      score_bin  <= '0;
      bcd        <= '0;
      pending    <= '0;
      lives      <= START_L;
      blink_cnt  <= '0;
      extra_done <= 1'b0;
    end else begin
      pending   <= pend_next;
      score_bin <= score_next;
      bcd       <= bcd_next;
      lives     <= lives_inc;
      if (award) extra_done <= 1'b1;

      // Publish the values held before this cycle so a frame never shows a half-applied update.
      if (hud.frame_start) begin
        score_out_r <= score_bin;
        score_bcd_r <= bcd;
        lives_out_r <= lives;
        blank_r     <= (state == HIT) && blink_cnt[2];
      end

      case (state)
        PLAY: begin
          if (hit) begin
            lives <= lives_hit;
            if (lives_hit != 2'd0) begin
              state     <= HIT;
              blink_cnt <= BLINK_N;
            end else begin
              state <= OVER;
            end
          end
        end
        HIT: begin
          if (hud.frame_start) begin
            if (blink_cnt <= 8'd1) begin
              blink_cnt <= 8'd0;
              state     <= PLAY;
            end else begin
              blink_cnt <= blink_cnt - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hud.score_out       = score_out_r;
  assign hud.score_bcd       = score_bcd_r;
  assign hud.lives_out       = lives_out_r;
  assign hud.hud_blank_lives = blank_r;
  assign hud.game_over       = (state == OVER);
  assign hud.busy            = drain;
endmodule
